div_element_sequencer: RTL and testbench
========================================

# div_element_sequencer

Element sequencer sitting directly upstream of the vector lane divide unit. It accepts one divide element at a time from the lane's operand stage, launches the multi-cycle divider with a single-cycle start pulse, and waits for its done pulse. It resolves RVV special cases locally (masked-off, divide-by-zero, signed overflow) without touching the divider. It then presents the result to writeback with a valid/ready handshake and an element index.

## Interface
- ELEM_W, default 5: element index width (up to 32 elements per vector op).
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- op_valid  in  1  element operands valid.
- op_ready  out  1  sequencer can accept an element.
- op_vs1  in  32  divisor.
- op_vs2  in  32  dividend.
- op_vd_old  in  32  old destination value, used for masked-off elements.
- op_mask  in  1  1 = active element.
- op_signed  in  1  signed divide/remainder.
- op_div_type  in  1  1 = quotient, 0 = remainder.
- op_last  in  1  last element of the vector op.
- flush  in  1  abort the current op.
- start_div  out  1  one-cycle start pulse to the divide unit.
- vs1_data, vs2_data  out  32 each  divisor and dividend; held stable while the divider is busy.
- is_signed_div, div_type  out  1 each  held with the operands.
- done_du  in  1  divider finished; one-cycle pulse.
- wdata_du  in  32  divider result, valid when done_du = 1.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts the result.
- wb_data  out  32  element result.
- wb_idx  out  ELEM_W  element index.
- wb_last  out  1  result belongs to the last element.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT, RESULT, DRAIN.
- IDLE: op_ready = 1. On op_valid, register the operands, the control bits and op_last, then classify the element:
  - op_mask = 0: result = op_vd_old; go to RESULT.
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend; go to RESULT.
  - Signed, dividend 0x80000000, divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0; go to RESULT.
  - Otherwise: go to LAUNCH.
- LAUNCH: start_div = 1 for exactly this cycle; go to WAIT.
- WAIT: hold the operand outputs. On done_du, capture wdata_du into the result register and go to RESULT.
- RESULT: wb_valid = 1; wb_data, wb_idx and wb_last stay stable until accepted. On wb_ready:
  - Go to IDLE.
  - Element counter: +1, or cleared to 0 if wb_last.
- Element counter: ELEM_W bits, wraps modulo 2^ELEM_W. wb_idx = counter value at acceptance of the result.
- flush:
  - In IDLE, LAUNCH or RESULT: go to IDLE, counter = 0, result discarded, no start_div.
  - In WAIT: go to DRAIN, because the divider cannot be aborted.
  - DRAIN: wait for done_du, discard the result, go to IDLE with counter = 0. op_ready stays 0 in DRAIN.
  - flush in LAUNCH suppresses the start_div pulse for that cycle.
- A flush arriving together with op_valid in IDLE wins: the element is not accepted.
- done_du outside WAIT/DRAIN is ignored.

## Timing
- Reset values: state IDLE, counter 0, op_ready 1, start_div 0, wb_valid 0, wb_data 0, wb_idx 0, wb_last 0, busy 0, vs1_data/vs2_data 0, is_signed_div 0, div_type 0.
- Reset mid-operation: immediate return to reset values, with no wait for the divider.
- Bypass latency: accepted at edge N, wb_valid high in cycle N+1.
- Divided element: accepted at edge N, start_div in cycle N+1, WAIT from N+2. wb_valid rises the cycle after the done_du cycle.
- No element overlap: op_ready = 0 from acceptance until wb handshake completes. Peak throughput is therefore 1 element / 2 cycles for bypass elements.
- All outputs are registered or state-decoded; there is no combinational path from op_* or wb_ready to any output.

## Test plan
- Unsigned 100 / 7, quotient: start_div is one pulse; done_du 34 cycles later with wdata_du = 14 -> wb_data 14, wb_idx 0, wb_last per stimulus.
- Signed, vs2 0x80000000, vs1 0xFFFFFFFF, remainder -> no start_div; wb_data 0 one cycle after accept. Same operands as quotient -> wb_data 0x80000000.
- Divisor 0, dividend 0x12345678 -> quotient 0xFFFFFFFF; remainder 0x12345678. start_div never asserted.
- Four elements, element 2 masked with vd_old 0xDEAD0000, last on element 3, wb_ready low for 3 cycles on element 1 -> wb_idx 0,1,2,3, data held stable while stalled; counter back to 0 after element 3.
- flush during WAIT -> DRAIN, op_ready 0 until done_du, no wb_valid; the next element gets wb_idx 0.
- nRST low during WAIT -> all outputs return to reset values asynchronously; a stale done_du after reset produces no wb_valid.

Source files
------------

// File: rtl/div_element_sequencer_if.sv
// div_element_sequencer_if
//   Groups every non-clock signal of the divide element sequencer.
//   Operand side : op_valid/op_ready handshake plus op_vs1, op_vs2, op_vd_old,
//                  op_mask, op_signed, op_div_type, op_last, and the flush abort.
//   Divider side : start_div pulse, held operands vs1_data/vs2_data,
//                  is_signed_div/div_type, and the done_du/wdata_du return.
//   Writeback    : wb_valid/wb_ready handshake with wb_data, wb_idx, wb_last.
//   Status       : busy.
//   Modport slave is the sequencer's view; modport master is the surrounding
//   lane (operand stage, divide unit and writeback combined).
interface div_element_sequencer_if #(
    parameter int ELEM_W = 5
);
    logic              op_valid;
    logic              op_ready;
    logic [31:0]       op_vs1;
    logic [31:0]       op_vs2;
    logic [31:0]       op_vd_old;
    logic              op_mask;
    logic              op_signed;
    logic              op_div_type;
    logic              op_last;
    logic              flush;
    logic              start_div;
    logic [31:0]       vs1_data;
    logic [31:0]       vs2_data;
    logic              is_signed_div;
    logic              div_type;
    logic              done_du;
    logic [31:0]       wdata_du;
    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_data;
    logic [ELEM_W-1:0] wb_idx;
    logic              wb_last;
    logic              busy;

    modport slave (
        input  op_valid, op_vs1, op_vs2, op_vd_old, op_mask, op_signed,
               op_div_type, op_last, flush, done_du, wdata_du, wb_ready,
        output op_ready, start_div, vs1_data, vs2_data, is_signed_div,
               div_type, wb_valid, wb_data, wb_idx, wb_last, busy
    );

    modport master (
        output op_valid, op_vs1, op_vs2, op_vd_old, op_mask, op_signed,
               op_div_type, op_last, flush, done_du, wdata_du, wb_ready,
        input  op_ready, start_div, vs1_data, vs2_data, is_signed_div,
               div_type, wb_valid, wb_data, wb_idx, wb_last, busy
    );
endinterface

// File: rtl/div_element_sequencer.sv
// div_element_sequencer
//   Accepts one divide element at a time, resolves the RVV special cases
//   (masked-off, divide-by-zero, signed overflow) locally, launches the
//   multi-cycle divider with a one-cycle start pulse for everything else, and
//   hands the result to writeback with an element index.
//   Ports: CLK (rising edge), nRST (async active-low), bus (slave modport of
//   div_element_sequencer_if carrying operand, divider and writeback signals).
module div_element_sequencer #(
    parameter int ELEM_W = 5
) (
    input logic                   CLK,
    input logic                   nRST,
    div_element_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESULT = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    state_t            state_r;
    logic [ELEM_W-1:0] cnt_r;
    logic [31:0]       result_r;
    logic [31:0]       vs1_r;
    logic [31:0]       vs2_r;
    logic              signed_r;
    logic              div_type_r;
    logic              last_r;
    logic [32:0]       class_s;

    // Returns {bypass, result}; bypass = 1 when the element never needs the divider.
    function automatic logic [32:0] classify(
        input logic        mask,
        input logic        sgn,
        input logic        quot,
        input logic [31:0] vs1,
        input logic [31:0] vs2,
        input logic [31:0] vd_old
    );
        logic [32:0] res;
        if (!mask) begin
            res = {1'b1, vd_old};
        end else if (vs1 == 32'h0000_0000) begin
            res = {1'b1, (quot ? 32'hFFFF_FFFF : vs2)};
        end else if (sgn && (vs2 == 32'h8000_0000) && (vs1 == 32'hFFFF_FFFF)) begin
            res = {1'b1, (quot ? 32'h8000_0000 : 32'h0000_0000)};
        end else begin
            res = {1'b0, 32'h0000_0000};
        end
        return res;
    endfunction

    assign class_s = classify(bus.op_mask, bus.op_signed, bus.op_div_type,
                              bus.op_vs1, bus.op_vs2, bus.op_vd_old);

    // Status and strobe outputs decode the state register; flush gates the
    // start pulse so an abort in LAUNCH never reaches the divider.
    assign bus.op_ready      = (state_r == ST_IDLE);
    assign bus.busy          = (state_r != ST_IDLE);
    assign bus.wb_valid      = (state_r == ST_RESULT);
    assign bus.start_div     = (state_r == ST_LAUNCH) && !bus.flush;
    assign bus.wb_data       = result_r;
    assign bus.wb_idx        = cnt_r;
    assign bus.wb_last       = last_r;
    assign bus.vs1_data      = vs1_r;
    assign bus.vs2_data      = vs2_r;
    assign bus.is_signed_div = signed_r;
    assign bus.div_type      = div_type_r;

    // Sequencer FSM with its operand, result and element-counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            result_r   <= 32'h0000_0000;
            vs1_r      <= 32'h0000_0000;
            vs2_r      <= 32'h0000_0000;
            signed_r   <= 1'b0;
            div_type_r <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.flush) begin
                        cnt_r <= '0;
                    end else if (bus.op_valid) begin
                        vs1_r      <= bus.op_vs1;
                        vs2_r      <= bus.op_vs2;
                        signed_r   <= bus.op_signed;
                        div_type_r <= bus.op_div_type;
                        last_r     <= bus.op_last;
                        if (class_s[32]) begin
                            result_r <= class_s[31:0];
                            state_r  <= ST_RESULT;
                        end else begin
                            state_r  <= ST_LAUNCH;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    if (bus.flush) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A flush coinciding with done has nothing left to drain.
                    if (bus.flush && bus.done_du) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else if (bus.flush) begin
                        state_r <= ST_DRAIN;
                    end else if (bus.done_du) begin
                        result_r <= bus.wdata_du;
                        state_r  <= ST_RESULT;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESULT: begin
                    if (bus.flush) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else if (bus.wb_ready) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= last_r ? '0 : (cnt_r + ELEM_W'(1));
                    end else begin
                        state_r <= ST_RESULT;
                    end
                end
                ST_DRAIN: begin
                    if (bus.done_du) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_element_sequencer.sv
// tb_div_element_sequencer
//   Scoreboard bench: the stimulus process pushes the expected writeback beat
//   (data, index, last) when an element is accepted; a monitor pops and compares
//   on every wb handshake. A behavioural divide unit answers start pulses.
module tb_div_element_sequencer;
    localparam int ELEM_W = 5;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    div_element_sequencer_if #(.ELEM_W(ELEM_W)) bus ();
    div_element_sequencer #(.ELEM_W(ELEM_W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    typedef struct packed {
        logic [31:0]       data;
        logic [ELEM_W-1:0] idx;
        logic              last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   starts = 0;
    int   exp_starts = 0;
    int   cnt_m = 0;
    int   div_lat = 0;
    int   rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] div_calc(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn, input logic quot);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (sgn) return quot ? 32'(sa / sb) : 32'(sa % sb);
        return quot ? (a / b) : (a % b);
    endfunction

    function automatic logic is_bypass(input logic mask, input logic sgn,
                                       input logic [31:0] vs1, input logic [31:0] vs2);
        return !mask || (vs1 == 32'd0) || (sgn && vs2 == 32'h8000_0000 && vs1 == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic mask, input logic sgn, input logic quot,
                                               input logic [31:0] vs1, input logic [31:0] vs2,
                                               input logic [31:0] vd_old);
        if (!mask) return vd_old;
        if (vs1 == 32'd0) return quot ? 32'hFFFF_FFFF : vs2;
        if (sgn && vs2 == 32'h8000_0000 && vs1 == 32'hFFFF_FFFF) return quot ? 32'h8000_0000 : 32'd0;
        return div_calc(vs2, vs1, sgn, quot);
    endfunction

    // Issue one element, record its expected beat, check first-cycle behaviour.
    task automatic send(input logic mask, input logic sgn, input logic quot, input logic last,
                        input logic [31:0] vs1, input logic [31:0] vs2, input logic [31:0] vd_old);
        int   waitc;
        logic byp;
        exp_t e;
        @(posedge CLK); #1;
        bus.op_mask = mask; bus.op_signed = sgn; bus.op_div_type = quot; bus.op_last = last;
        bus.op_vs1 = vs1; bus.op_vs2 = vs2; bus.op_vd_old = vd_old; bus.op_valid = 1'b1;
        waitc = 0;
        @(negedge CLK);
        while (!bus.op_ready && waitc < 300) begin
            @(negedge CLK);
            waitc++;
        end
        if (!bus.op_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: op_ready got 0 expected 1 at %0t", $time);
            bus.op_valid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        bus.op_valid = 1'b0;
        byp = is_bypass(mask, sgn, vs1, vs2);
        e.data = ref_result(mask, sgn, quot, vs1, vs2, vd_old);
        e.idx  = ELEM_W'(cnt_m);
        e.last = last;
        exp_q.push_back(e);
        cnt_m = last ? 0 : ((cnt_m + 1) % (1 << ELEM_W));
        if (!byp) exp_starts++;
        @(negedge CLK);
        if (byp) chk("bypass_latency_wb_valid", bus.wb_valid, 1'b1);
        else     chk("launch_start_div", bus.start_div, 1'b1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !bus.op_ready) && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 2000) begin
            n_cmp++; n_fail++;
            $display("FAIL idle_timeout: queue %0d op_ready %0b expected empty/1", exp_q.size(), bus.op_ready);
        end
    endtask

    // Behavioural divide unit: answers each start pulse after a latency.
    initial begin
        logic [31:0] a, b;
        logic        s, t;
        int          lat;
        bus.done_du = 1'b0;
        bus.wdata_du = 32'd0;
        forever begin
            @(negedge CLK);
            if (bus.start_div) begin
                a = bus.vs2_data; b = bus.vs1_data; s = bus.is_signed_div; t = bus.div_type;
                lat = (div_lat > 0) ? div_lat : $urandom_range(1, 12);
                repeat (lat) @(posedge CLK);
                #1;
                bus.done_du = 1'b1;
                bus.wdata_du = div_calc(a, b, s, t);
                @(negedge CLK);
                if (bus.busy) begin
                    chk("operand_hold_vs1", bus.vs1_data, b);
                    chk("operand_hold_vs2", bus.vs2_data, a);
                end
                @(posedge CLK); #1;
                bus.done_du = 1'b0;
                bus.wdata_du = $urandom;
            end
        end
    end

    // Count start pulses; a stretched pulse counts more than once.
    initial forever begin
        @(negedge CLK);
        if (bus.start_div) starts++;
    end

    // Writeback ready: random, always-on, or three stall cycles per beat.
    initial begin
        int sc;
        sc = 0;
        bus.wb_ready = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (!bus.wb_valid) sc = 0;
            case (rdy_mode)
                0: bus.wb_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                1: bus.wb_ready = 1'b1;
                default: begin
                    bus.wb_ready = (sc >= 3) ? 1'b1 : 1'b0;
                    if (bus.wb_valid) sc++;
                end
            endcase
        end
    end

    // Monitor: stability under stall, no spurious beats, scoreboard compare.
    initial begin
        exp_t e;
        exp_t prev;
        logic have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                have_prev = 1'b0;
            end else if (bus.wb_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_wb_valid: got beat data %h idx %0d expected none", bus.wb_data, bus.wb_idx);
                end
                if (have_prev) begin
                    chk("stall_hold_data", bus.wb_data, prev.data);
                    chk("stall_hold_idx", bus.wb_idx, prev.idx);
                    chk("stall_hold_last", bus.wb_last, prev.last);
                end
                if (bus.wb_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wb_data", bus.wb_data, e.data);
                    chk("wb_idx", bus.wb_idx, e.idx);
                    chk("wb_last", bus.wb_last, e.last);
                    have_prev = 1'b0;
                end else begin
                    prev.data = bus.wb_data; prev.idx = bus.wb_idx; prev.last = bus.wb_last;
                    have_prev = 1'b1;
                end
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        int          s0, k, kind;
        logic [31:0] r1, r2, r3;
        logic        m, sg, q, l;
        nRST = 1'b0;
        bus.op_valid = 1'b0; bus.op_vs1 = 32'd0; bus.op_vs2 = 32'd0; bus.op_vd_old = 32'd0;
        bus.op_mask = 1'b0; bus.op_signed = 1'b0; bus.op_div_type = 1'b0; bus.op_last = 1'b0;
        bus.flush = 1'b0;
        #12;
        chk("rst_op_ready", bus.op_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_idx", bus.wb_idx, 32'd0);
        chk("rst_wb_last", bus.wb_last, 1'b0);
        chk("rst_start_div", bus.start_div, 1'b0);
        chk("rst_vs1_data", bus.vs1_data, 32'd0);
        chk("rst_vs2_data", bus.vs2_data, 32'd0);
        chk("rst_is_signed", bus.is_signed_div, 1'b0);
        chk("rst_div_type", bus.div_type, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;

        // Unsigned 100 / 7 with a 34-cycle divider.
        rdy_mode = 1; div_lat = 34; s0 = starts;
        send(1'b1, 1'b0, 1'b1, 1'b1, 32'd7, 32'd100, 32'd0);
        wait_idle();
        chk("single_start_pulse", 32'(starts - s0), 32'd1);

        // Signed overflow and divide-by-zero never reach the divider.
        div_lat = 0; s0 = starts;
        send(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        send(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h1234_5678, 32'd0);
        send(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h1234_5678, 32'd0);
        wait_idle();
        chk("special_no_start", 32'(starts - s0), 32'd0);

        // Four elements, third masked, three-cycle stalls on every beat.
        rdy_mode = 2;
        send(1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd1000, 32'd0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd50, 32'd0);
        send(1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 32'd9, 32'hDEAD_0000);
        send(1'b1, 1'b0, 1'b0, 1'b1, 32'd10, 32'd77, 32'd0);
        wait_idle();
        chk("cnt_cleared_after_last", bus.wb_idx, 32'd0);
        rdy_mode = 0;

        // Flush while the divider is busy: drain, no beat, counter cleared.
        send(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1, 32'd0);
        wait_idle();
        div_lat = 20;
        send(1'b1, 1'b0, 1'b1, 1'b0, 32'd9, 32'd99, 32'd0);
        repeat (4) @(posedge CLK);
        #1 bus.flush = 1'b1;
        @(posedge CLK); #1;
        bus.flush = 1'b0;
        exp_q.delete();
        cnt_m = 0;
        k = 0;
        while (k < 40) begin
            @(negedge CLK);
            if (bus.done_du) break;
            chk("drain_op_ready", bus.op_ready, 1'b0);
            chk("drain_wb_valid", bus.wb_valid, 1'b0);
            k++;
        end
        if (k >= 40) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_done_timeout: no done_du seen within 40 cycles");
        end
        @(negedge CLK);
        chk("after_drain_op_ready", bus.op_ready, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'hCAFE_F00D);
        wait_idle();

        // Asynchronous reset while waiting; the stale done must be ignored.
        send(1'b1, 1'b0, 1'b0, 1'b0, 32'd4, 32'd42, 32'd0);
        repeat (3) @(posedge CLK);
        #3 nRST = 1'b0;
        #1;
        chk("async_rst_busy", bus.busy, 1'b0);
        chk("async_rst_op_ready", bus.op_ready, 1'b1);
        chk("async_rst_start_div", bus.start_div, 1'b0);
        chk("async_rst_vs1_data", bus.vs1_data, 32'd0);
        chk("async_rst_vs2_data", bus.vs2_data, 32'd0);
        chk("async_rst_wb_idx", bus.wb_idx, 32'd0);
        exp_q.delete();
        cnt_m = 0;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (30) @(negedge CLK);
        chk("stale_done_op_ready", bus.op_ready, 1'b1);
        chk("stale_done_busy", bus.busy, 1'b0);

        // Flush together with op_valid in IDLE: element refused, counter cleared.
        div_lat = 0;
        send(1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'h0000_0011);
        wait_idle();
        @(posedge CLK); #1;
        bus.op_mask = 1'b0; bus.op_vd_old = 32'h0BAD_0BAD; bus.op_valid = 1'b1; bus.flush = 1'b1;
        @(posedge CLK); #1;
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        cnt_m = 0;
        @(negedge CLK);
        chk("flush_wins_wb_valid", bus.wb_valid, 1'b0);
        chk("flush_wins_busy", bus.busy, 1'b0);

        // Randomized elements against the reference model.
        for (int e = 0; e < 60; e++) begin
            kind = $urandom_range(0, 9);
            r1 = $urandom; r2 = $urandom; r3 = $urandom;
            m = 1'b1; sg = $urandom_range(0, 1) != 0; q = $urandom_range(0, 1) != 0;
            l = $urandom_range(0, 4) == 0;
            case (kind)
                0: m = 1'b0;
                1: r1 = 32'd0;
                2: begin sg = 1'b1; r1 = 32'hFFFF_FFFF; r2 = 32'h8000_0000; end
                3: r1 = 32'($urandom_range(1, 9));
                default: r3 = r3;
            endcase
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            send(m, sg, q, l, r1, r2, r3);
        end
        wait_idle();
        chk("start_count", 32'(starts), 32'(exp_starts));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
